// File: rtl/booth_mult_scheduler.sv
// ============================================================================
// Module   : booth_mult_scheduler
// Purpose  : Two-port round-robin front end and radix-4 Booth sequencer for
//            an external 8x8 signed multiplier datapath.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module booth_mult_scheduler (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  req_valid,
  output logic [1:0]  req_ready,
  input  logic [7:0]  req_m0,
  input  logic [7:0]  req_q0,
  input  logic [7:0]  req_m1,
  input  logic [7:0]  req_q1,
  output logic [1:0]  rsp_valid,
  input  logic [1:0]  rsp_ready,
  output logic [15:0] rsp_p,
  output logic [7:0]  dp_ctrl,
  output logic [7:0]  dp_m,
  output logic [7:0]  dp_q,
  input  logic [1:0]  dp_q_lsb,
  input  logic        dp_qm1,
  input  logic        dp_zero_count,
  input  logic [7:0]  dp_out_a,
  input  logic [7:0]  dp_out_q,
  output logic        busy,
  output logic        grant_id,
  output logic        err
);

  // Bit positions of the datapath pulses inside dp_ctrl
  localparam int c_c0 = 0;
  localparam int c_c1 = 1;
  localparam int c_c2 = 2;
  localparam int c_c3 = 3;
  localparam int c_c4 = 4;
  localparam int c_c5 = 5;
  localparam int c_c7 = 6;
  localparam int c_c8 = 7;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    INIT  = 3'd1,
    EVAL  = 3'd2,
    SHIFT = 3'd3,
    OUT   = 3'd4,
    RESP  = 3'd5
  } state_t;

  state_t      r_state;
  logic [1:0]  r_iter;
  logic        r_last;
  logic        r_grant;
  logic        r_err;
  logic [7:0]  r_m;
  logic [7:0]  r_q;
  logic [15:0] r_p;
  logic [1:0]  r_rsp_valid;

  logic        w_win;
  logic [1:0]  w_req_ready;
  logic        w_accept;
  logic        w_rsp_hs;
  logic [7:0]  w_ctrl;

  // With both ports asking, the one not served last wins
  always_comb begin
    w_win = 1'b0;
    if (req_valid == 2'b11) begin
      w_win = ~r_last;
    end else begin
      w_win = req_valid[1];
    end
  end

  assign w_req_ready = (rst_n && (r_state == IDLE) && req_valid[w_win]) ?
                       (2'b01 << w_win) : 2'b00;
  assign w_accept    = |(req_valid & w_req_ready);
  assign w_rsp_hs    = (r_state == RESP) && (|(r_rsp_valid & rsp_ready));

  always_comb begin
    w_ctrl = 8'h00;
    case (r_state)
      INIT: begin
        w_ctrl[c_c0] = 1'b1;
        w_ctrl[c_c1] = 1'b1;
      end
      EVAL: begin
        case ({dp_q_lsb, dp_qm1})
          3'b001, 3'b010: begin
            w_ctrl[c_c2] = 1'b1;
          end
          3'b011: begin
            w_ctrl[c_c2] = 1'b1;
            w_ctrl[c_c3] = 1'b1;
          end
          3'b100: begin
            w_ctrl[c_c2] = 1'b1;
            w_ctrl[c_c3] = 1'b1;
            w_ctrl[c_c4] = 1'b1;
          end
          3'b101, 3'b110: begin
            w_ctrl[c_c2] = 1'b1;
            w_ctrl[c_c4] = 1'b1;
          end
          default: begin
            w_ctrl = 8'h00;
          end
        endcase
      end
      SHIFT: begin
        w_ctrl[c_c5] = 1'b1;
      end
      OUT: begin
        w_ctrl[c_c7] = 1'b1;
        w_ctrl[c_c8] = 1'b1;
      end
      default: begin
        w_ctrl = 8'h00;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_iter      <= 2'd0;
      r_last      <= 1'b1;
      r_grant     <= 1'b0;
      r_err       <= 1'b0;
      r_m         <= 8'h00;
      r_q         <= 8'h00;
      r_p         <= 16'h0000;
      r_rsp_valid <= 2'b00;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_m     <= w_win ? req_m1 : req_m0;
            r_q     <= w_win ? req_q1 : req_q0;
            r_grant <= w_win;
            r_state <= INIT;
          end
        end
        INIT: begin
          r_iter  <= 2'd0;
          r_state <= EVAL;
        end
        EVAL: begin
          r_state <= SHIFT;
        end
        SHIFT: begin
          r_iter  <= r_iter + 2'd1;
          r_state <= (r_iter == 2'd3) ? OUT : EVAL;
        end
        OUT: begin
          r_p <= {dp_out_a, dp_out_q};
          if (!dp_zero_count) begin
            r_err <= 1'b1;
          end
          r_state <= RESP;
        end
        RESP: begin
          // Valid is registered, so it rises one cycle into RESP
          if (w_rsp_hs) begin
            r_rsp_valid <= 2'b00;
            r_last      <= r_grant;
            r_state     <= IDLE;
          end else begin
            r_rsp_valid <= 2'b01 << r_grant;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign req_ready = w_req_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_p     = r_p;
  assign dp_ctrl   = w_ctrl;
  assign dp_m      = r_m;
  assign dp_q      = r_q;
  assign busy      = (r_state != IDLE);
  assign grant_id  = r_grant;
  assign err       = r_err;

endmodule

`default_nettype wire

// File: tb/tb_booth_mult_scheduler.sv
// ============================================================================
// Module   : tb_booth_mult_scheduler
// Purpose  : Directed bench with a behavioural radix-4 Booth datapath.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_booth_mult_scheduler;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [7:0]  req_m0, req_q0, req_m1, req_q1;
  logic [1:0]  rsp_valid;
  logic [1:0]  rsp_ready;
  logic [15:0] rsp_p;
  logic [7:0]  dp_ctrl, dp_m, dp_q;
  logic [1:0]  dp_q_lsb;
  logic        dp_qm1, dp_zero_count;
  logic [7:0]  dp_out_a, dp_out_q;
  logic        busy, grant_id, err;

  int checks   = 0;
  int failures = 0;
  logic exp_err = 1'b0;
  logic force_nz = 1'b0;

  always #5 clk = ~clk;

  booth_mult_scheduler u_dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_m0(req_m0), .req_q0(req_q0), .req_m1(req_m1), .req_q1(req_q1),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_p(rsp_p),
    .dp_ctrl(dp_ctrl), .dp_m(dp_m), .dp_q(dp_q),
    .dp_q_lsb(dp_q_lsb), .dp_qm1(dp_qm1), .dp_zero_count(dp_zero_count),
    .dp_out_a(dp_out_a), .dp_out_q(dp_out_q),
    .busy(busy), .grant_id(grant_id), .err(err)
  );

  // Behavioural datapath: A is 10 bits wide to hold +/-2M without overflow
  logic signed [9:0] dp_a = '0;
  logic [7:0]        dp_mr = '0;
  logic [7:0]        dp_qr = '0;
  logic              dp_qm1r = 1'b0;
  logic [2:0]        dp_cnt = '0;
  logic signed [9:0] w_base;
  logic [18:0]       w_sh;

  assign w_base = dp_ctrl[3] ? $signed({dp_mr[7], dp_mr, 1'b0})
                             : $signed({{2{dp_mr[7]}}, dp_mr});
  assign w_sh   = $signed({dp_a, dp_qr, dp_qm1r}) >>> 2;

  always @(posedge clk) begin
    if (dp_ctrl[0]) begin
      dp_mr   <= dp_m;
      dp_a    <= '0;
      dp_qm1r <= 1'b0;
    end
    if (dp_ctrl[1]) begin
      dp_qr  <= dp_q;
      dp_cnt <= 3'd4;
    end
    if (dp_ctrl[2]) begin
      dp_a <= dp_ctrl[4] ? (dp_a - w_base) : (dp_a + w_base);
    end
    if (dp_ctrl[5]) begin
      {dp_a, dp_qr, dp_qm1r} <= w_sh;
      dp_cnt <= dp_cnt - 3'd1;
    end
  end

  assign dp_q_lsb      = dp_qr[1:0];
  assign dp_qm1        = dp_qm1r;
  assign dp_out_a      = dp_a[7:0];
  assign dp_out_q      = dp_qr;
  assign dp_zero_count = force_nz ? 1'b0 : (dp_cnt == 3'd0);

  typedef struct {
    logic        port;
    logic [7:0]  m;
    logic [7:0]  q;
    logic [15:0] p;
  } vec_t;

  vec_t vecs [10];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] eval_exp(input logic [2:0] b);
    case (b)
      3'b001, 3'b010: return 8'h04;
      3'b011:         return 8'h0C;
      3'b100:         return 8'h1C;
      3'b101, 3'b110: return 8'h14;
      default:        return 8'h00;
    endcase
  endfunction

  function automatic logic [46:0] all_outs();
    return {req_ready, rsp_valid, rsp_p, dp_ctrl, dp_m, dp_q, busy, grant_id, err};
  endfunction

  task automatic run_op(input logic [1:0] valid, input logic exp_g, input logic [15:0] exp_p,
                        input int stall, input bit force_err);
    int k;
    bit got;
    bit ok;
    logic [7:0] sm, sq, exp_c;
    req_valid = valid;
    #1;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      if ((req_valid & req_ready) != 2'b00) got = 1'b1;
      else tick();
    end
    check("accept_seen", 64'(got), 64'(1));
    if (!got) begin
      req_valid = 2'b00;
      return;
    end
    check("req_ready_grant", 64'(req_ready), 64'(2'b01 << exp_g));
    tick();
    check("init_state", 64'({busy, grant_id, req_ready, dp_ctrl}),
          64'({1'b1, exp_g, 2'b00, 8'h03}));
    // Change the granted port's operands: the result must not follow them
    if (exp_g) begin
      sm = req_m1; sq = req_q1; req_m1 = ~req_m1; req_q1 = req_q1 + 8'd37;
    end else begin
      sm = req_m0; sq = req_q0; req_m0 = ~req_m0; req_q0 = req_q0 + 8'd37;
    end
    ok = 1'b1;
    k  = 0;
    while (rsp_valid == 2'b00 && k < 40) begin
      tick();
      k++;
      if (k == 9 && force_err) force_nz = 1'b1;
      if (k == 10) begin
        force_nz = 1'b0;
        if (force_err) exp_err = 1'b1;
      end
      if (k <= 8) exp_c = (k % 2 == 1) ? eval_exp({dp_q_lsb, dp_qm1}) : 8'h20;
      else if (k == 9) exp_c = 8'hC0;
      else exp_c = 8'h00;
      if (dp_ctrl !== exp_c || busy !== 1'b1 || req_ready !== 2'b00) ok = 1'b0;
    end
    check("latency", 64'(k), 64'(11));
    check("ctrl_sequence", 64'(ok), 64'(1));
    check("rsp_valid", 64'(rsp_valid), 64'(2'b01 << exp_g));
    check("rsp_p", 64'(rsp_p), 64'(exp_p));
    check("err", 64'(err), 64'(exp_err));
    if (stall > 0) begin
      ok = 1'b1;
      for (int i = 0; i < stall; i++) begin
        tick();
        if (rsp_valid !== (2'b01 << exp_g) || rsp_p !== exp_p ||
            req_ready !== 2'b00 || busy !== 1'b1) ok = 1'b0;
      end
      check("stall_hold", 64'(ok), 64'(1));
    end
    rsp_ready = 2'b01 << exp_g;
    tick();
    rsp_ready = 2'b00;
    check("after_handshake", 64'({rsp_valid, busy}), 64'(0));
    if (valid != 2'b00) check("next_ready", 64'(req_ready != 2'b00), 64'(1));
    if (exp_g) begin
      req_m1 = sm; req_q1 = sq;
    end else begin
      req_m0 = sm; req_q0 = sq;
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    bit ok;
    vecs[0] = '{1'b0, 8'd7,   8'd3,   16'h0015};
    vecs[1] = '{1'b1, 8'h80,  8'h80,  16'h4000};
    vecs[2] = '{1'b1, 8'hFB,  8'd6,   16'hFFE2};
    vecs[3] = '{1'b0, 8'd127, 8'd127, 16'h3F01};
    vecs[4] = '{1'b0, 8'h80,  8'd127, 16'hC080};
    vecs[5] = '{1'b1, 8'hFF,  8'hFF,  16'h0001};
    vecs[6] = '{1'b0, 8'd0,   8'hB3,  16'h0000};
    vecs[7] = '{1'b1, 8'h80,  8'd1,   16'hFF80};
    vecs[8] = '{1'b0, 8'd85,  8'hFD,  16'hFF01};
    vecs[9] = '{1'b1, 8'd127, 8'h80,  16'hC080};

    rst_n = 1'b0;
    req_valid = 2'b11;
    rsp_ready = 2'b00;
    req_m0 = 8'h11; req_q0 = 8'h22; req_m1 = 8'h33; req_q1 = 8'h44;
    repeat (3) tick();
    check("reset_outputs", 64'(all_outs()), 64'(0));
    rst_n = 1'b1;
    req_valid = 2'b00;
    tick();

    for (int i = 0; i < 10; i++) begin
      if (vecs[i].port) begin
        req_m1 = vecs[i].m; req_q1 = vecs[i].q;
      end else begin
        req_m0 = vecs[i].m; req_q0 = vecs[i].q;
      end
      run_op(2'b01 << vecs[i].port, vecs[i].port, vecs[i].p, 0, 1'b0);
    end
    req_valid = 2'b00;
    tick();

    // Serve port 0 last, then reset: the pointer must return to port-0 priority
    req_m0 = 8'd2; req_q0 = 8'd5;
    run_op(2'b01, 1'b0, 16'h000A, 0, 1'b0);
    req_valid = 2'b00;
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    req_m0 = 8'd3;  req_q0 = 8'd4;
    req_m1 = 8'hFE; req_q1 = 8'd9;
    run_op(2'b11, 1'b0, 16'h000C, 0, 1'b0);
    run_op(2'b11, 1'b1, 16'hFFEE, 0, 1'b0);
    run_op(2'b11, 1'b0, 16'h000C, 20, 1'b0);
    run_op(2'b11, 1'b1, 16'hFFEE, 0, 1'b0);
    req_valid = 2'b00;
    tick();

    // Abort during the third EVAL
    req_m0 = 8'd9; req_q0 = 8'd9;
    req_valid = 2'b01;
    #1;
    check("midop_ready", 64'(req_ready), 64'(2'b01));
    tick();
    req_valid = 2'b00;
    repeat (5) tick();
    check("midop_in_eval", 64'({busy, dp_ctrl[7:5]}), 64'(4'b1000));
    rst_n = 1'b0;
    #1;
    check("midop_reset_outputs", 64'(all_outs()), 64'(0));
    tick();
    tick();
    rst_n = 1'b1;
    ok = 1'b1;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (rsp_valid !== 2'b00 || busy !== 1'b0) ok = 1'b0;
    end
    check("midop_no_response", 64'(ok), 64'(1));
    req_m1 = 8'hF9; req_q1 = 8'd11;
    run_op(2'b10, 1'b1, 16'hFFB3, 0, 1'b0);
    req_valid = 2'b00;
    tick();

    // Counter not at zero in OUT: sticky error, product still delivered
    req_m0 = 8'hFD; req_q0 = 8'hFD;
    run_op(2'b01, 1'b0, 16'h0009, 0, 1'b1);
    req_valid = 2'b00;
    tick();
    req_m1 = 8'd10; req_q1 = 8'd10;
    run_op(2'b10, 1'b1, 16'h0064, 0, 1'b0);
    req_valid = 2'b00;
    repeat (3) tick();
    check("err_sticky_idle", 64'(err), 64'(1));
    rst_n = 1'b0;
    exp_err = 1'b0;
    #1;
    check("err_cleared_by_reset", 64'(err), 64'(0));
    tick();
    rst_n = 1'b1;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/booth_mult_scheduler.md
BOOTH_MULT_SCHEDULER -- requirements
Module: booth_mult_scheduler

Interface
REQ-001 SHALL have ports: clk  input  1  clock, rising edge; rst_n  input  1  reset, asynchronous, active-low.
REQ-002 SHALL have ports: req_valid  input  2  per-port operation request, bit i = port i.
REQ-003 SHALL have ports: req_ready  output  2  per-port accept, bit i = port i.
REQ-004 SHALL have ports: req_m0, req_q0, req_m1, req_q1  input  8 each  signed multiplicand M / multiplier Q for port 0 and port 1.
REQ-005 SHALL have ports: rsp_valid  output  2  per-port result valid; rsp_ready  input  2  per-port result accept.
REQ-006 SHALL have ports: rsp_p  output  16  signed product, meaningful only while a rsp_valid bit is high.
REQ-007 SHALL have ports: dp_ctrl  output  8  datapath pulses {c8,c7,c5,c4,c3,c2,c1,c0}; dp_m, dp_q  output  8 each  datapath D_M/D_Q.
REQ-008 SHALL have ports: dp_q_lsb  input  2  datapath Q[1:0]; dp_qm1  input  1  datapath Q-1; dp_zero_count  input  1  datapath counter zero.
REQ-009 SHALL have ports: dp_out_a, dp_out_q  input  8 each  datapath A and Q outputs.
REQ-010 SHALL have ports: busy  output  1  operation in progress; grant_id  output  1  port being served; err  output  1  sticky sequencing error.

Function
REQ-011 FSM states SHALL be IDLE, INIT, EVAL, SHIFT, OUT, RESP.
REQ-012 In IDLE, arbiter SHALL pick one requesting port round-robin: a sole requester wins; with both requesting, the port not served last wins; after reset, port 0 has priority.
REQ-013 req_ready SHALL be high only in IDLE and only for the winning port; the accept cycle is when req_valid and req_ready are both high for that port.
REQ-014 On accept, the block SHALL latch M, Q and grant_id, then go to INIT; dp_m/dp_q SHALL drive the latched operands from then until return to IDLE.
REQ-015 INIT: dp_ctrl SHALL assert c0 and c1 for exactly one cycle, then go to EVAL; the 2-bit internal iteration counter SHALL be cleared.
REQ-016 EVAL SHALL decode {dp_q_lsb,dp_qm1} for one cycle: 000/111 none; 001/010 c2; 011 c2+c3; 100 c2+c3+c4; 101/110 c2+c4; then go to SHIFT.
REQ-017 SHIFT SHALL assert c5 for one cycle and increment the iteration counter; after the 4th SHIFT it SHALL go to OUT, else to EVAL.
REQ-018 OUT SHALL assert c7 and c8 for one cycle and capture rsp_p = {dp_out_a, dp_out_q}.
REQ-019 In OUT, if dp_zero_count is 0, err SHALL be set and stay high until reset; the result is still delivered.
REQ-020 RESP: rsp_valid[grant_id] SHALL be high and rsp_p stable until rsp_ready[grant_id] is high; on that cycle, go to IDLE and record grant_id as last served.
REQ-021 Latency SHALL be fixed: rsp_valid rises exactly 11 cycles after the accept edge (INIT 1 + EVAL/SHIFT 8 + OUT 1 + 1).
REQ-022 No new request SHALL be accepted from accept through the RESP handshake cycle; the earliest next accept is the cycle after rsp handshake.
REQ-023 busy SHALL be high in every state except IDLE; dp_ctrl SHALL be 0 in IDLE and RESP, and all unlisted c-bits SHALL be 0 in every state.
REQ-024 req_valid withdrawn by a non-winning port SHALL have no effect; operand changes after accept SHALL not affect the result.
REQ-025 Product SHALL equal the 16-bit two's-complement product of signed 8-bit M and Q, including -128 operands.

Reset
REQ-026 While rst_n is low, the block SHALL be in IDLE, and req_ready, rsp_valid, rsp_p, dp_ctrl, dp_m, dp_q, busy, grant_id and err SHALL be 0; the last-served pointer SHALL favour port 0.
REQ-027 Reset asserted mid-operation SHALL abort it with no rsp_valid pulse; the first request after release SHALL follow REQ-012 from the reset state.

Verification
REQ-028 Port 0 M=7, Q=3 -> rsp_valid[0] 11 cycles after accept, rsp_p=0x0015, err=0.
REQ-029 Port 1 M=-128, Q=-128 -> rsp_p=0x4000; M=-5, Q=6 -> rsp_p=0xFFE2.
REQ-030 Both ports request continuously -> grants alternate 0,1,0,1 with grant_id matching; each port receives its own product.
REQ-031 rsp_ready held low for 20 cycles -> rsp_valid and rsp_p stay constant, req_ready stays 00, and there is no accept.
REQ-032 rst_n pulsed low during the third EVAL -> all outputs are 0 immediately, with no response; the next port-1-only request completes correctly.
REQ-033 dp_zero_count forced to 0 during OUT -> err=1 and stays high through later operations until reset.
